// File: rtl/alu_arbiter.sv
// Round-robin arbiter that sequences two requesters onto one shared 4-bit ALU.
// Each accepted op runs IDLE -> EXEC -> RESP and answers on the owner's response channel.

module alu_arbiter_alu (
    input  logic [3:0] i_op,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [3:0] o_result_c,
    output logic       o_zero_c
);
    localparam int unsigned DATA_W = 4;

    // Results wrap modulo 2^DATA_W; unknown codes yield zero.
    always_comb begin
        o_result_c = '0;
        case (i_op)
            4'b0000: o_result_c = i_a & i_b;
            4'b0001: o_result_c = i_a | i_b;
            4'b0010: o_result_c = i_a + i_b;
            4'b0100: o_result_c = i_a - i_b;
            4'b1000: o_result_c = DATA_W'(i_a < i_b);
            4'b0011: o_result_c = i_a << i_b[1:0];
            4'b0101: o_result_c = i_a >> i_b[1:0];
            4'b0110: o_result_c = i_a * i_b;
            4'b0111: o_result_c = i_a ^ i_b;
            default: o_result_c = '0;
        endcase
    end

    assign o_zero_c = (o_result_c == '0);
endmodule

module alu_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [3:0] rsp0_result,
    output logic       rsp0_zero,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [3:0] rsp1_result,
    output logic       rsp1_zero
);
    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [OP_W-1:0]    r_op;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  r_result;
    logic               r_zero;
    logic               r_owner;
    logic               r_last_grant;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_rsp_hs;
    logic [DATA_W-1:0]  w_alu_result;
    logic               w_alu_zero;

    alu_arbiter_alu u_alu (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_result_c (w_alu_result),
        .o_zero_c   (w_alu_zero)
    );

    // Grant only in IDLE and never while reset is asserted; contention goes to the one not served last.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if ((r_state == ST_IDLE) && !reset) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = !r_last_grant;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign w_rsp_hs   = r_owner ? (r_rsp1_valid && rsp1_ready)
                                : (r_rsp0_valid && rsp0_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_op         <= w_grant1 ? req1_op : req0_op;
                        r_a          <= w_grant1 ? req1_a  : req0_a;
                        r_b          <= w_grant1 ? req1_b  : req0_b;
                        r_owner      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result     <= w_alu_result;
                    r_zero       <= w_alu_zero;
                    r_rsp0_valid <= !r_owner;
                    r_rsp1_valid <= r_owner;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    // Result stays frozen until the owner takes it.
                    if (w_rsp_hs) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_zero   = r_zero;
    assign rsp1_zero   = r_zero;
endmodule
